// File: rtl/stream_packet_parser_if.sv
// Interface bundling the serial input and the parsed-output strobes of
// stream_packet_parser.
//   input_bit / is_new_input_bit : qualified serial bit stream (MSB first)
//   command / command_valid      : captured command field and its 1-cycle strobe
//   length                       : payload length (words) of current/last packet
//   data_out / data_valid        : assembled payload word and its 1-cycle strobe
//   packet_done                  : 1-cycle strobe at the end of each packet
//   busy                         : high whenever the parser is not hunting
// master: the bit source / output consumer; slave: the parser itself.
interface stream_packet_parser_if #(
  parameter int unsigned COMMAND_WIDTH = 16,
  parameter int unsigned LENGTH_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH    = 8
);
  logic                     input_bit;
  logic                     is_new_input_bit;
  logic [COMMAND_WIDTH-1:0] command;
  logic                     command_valid;
  logic [LENGTH_WIDTH-1:0]  length;
  logic [DATA_WIDTH-1:0]    data_out;
  logic                     data_valid;
  logic                     packet_done;
  logic                     busy;

  modport master (
    output input_bit, is_new_input_bit,
    input  command, command_valid, length, data_out, data_valid, packet_done, busy
  );

  modport slave (
    input  input_bit, is_new_input_bit,
    output command, command_valid, length, data_out, data_valid, packet_done, busy
  );
endinterface

// File: rtl/stream_packet_parser.sv
// Bit-serial packet framer. Hunts for HEADER with a sliding window, then
// captures a command field, a payload length field and that many payload
// words, then returns to hunting.
// Ports:
//   clk : clock
//   rst : synchronous active-high reset
//   bus : stream_packet_parser_if slave (serial input, parsed outputs)
module stream_packet_parser #(
  parameter int unsigned              HEADER_WIDTH  = 16,
  parameter logic [HEADER_WIDTH-1:0]  HEADER        = 16'hBACD,
  parameter int unsigned              COMMAND_WIDTH = 16,
  parameter int unsigned              LENGTH_WIDTH  = 16,
  parameter int unsigned              DATA_WIDTH    = 8
) (
  input logic                  clk,
  input logic                  rst,
  stream_packet_parser_if.slave bus
);

  localparam int unsigned CmdLenMax = (COMMAND_WIDTH > LENGTH_WIDTH) ? COMMAND_WIDTH
                                                                     : LENGTH_WIDTH;
  localparam int unsigned AsmWidth  = (CmdLenMax > DATA_WIDTH) ? CmdLenMax : DATA_WIDTH;
  localparam int unsigned CntWidth  = $clog2(AsmWidth + 1);
  localparam int unsigned FillWidth = $clog2(HEADER_WIDTH + 1);

  localparam logic [1:0] StHunt    = 2'd0;
  localparam logic [1:0] StCommand = 2'd1;
  localparam logic [1:0] StLength  = 2'd2;
  localparam logic [1:0] StPayload = 2'd3;

  logic [1:0]               state_q, state_d;
  // The window keeps only the HEADER_WIDTH-1 most recent bits; the incoming
  // bit completes the HEADER_WIDTH-bit comparison.
  logic [HEADER_WIDTH-2:0]  window_q, window_d;
  logic [HEADER_WIDTH-1:0]  window_next;
  logic [FillWidth-1:0]     fill_q, fill_d;
  logic [CntWidth-1:0]      bit_cnt_q, bit_cnt_d;
  logic [LENGTH_WIDTH-1:0]  word_cnt_q, word_cnt_d;
  // Shared field assembler; same trick as the window, the incoming bit is the LSB.
  logic [AsmWidth-2:0]      asm_q, asm_d;
  logic [AsmWidth-1:0]      asm_next;

  logic [COMMAND_WIDTH-1:0] command_q, command_d;
  logic                     command_valid_q, command_valid_d;
  logic [LENGTH_WIDTH-1:0]  length_q, length_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic                     data_valid_q, data_valid_d;
  logic                     packet_done_q, packet_done_d;

  always_comb begin
    window_next     = {window_q, bus.input_bit};
    asm_next        = {asm_q, bus.input_bit};

    state_d         = state_q;
    window_d        = window_q;
    fill_d          = fill_q;
    bit_cnt_d       = bit_cnt_q;
    word_cnt_d      = word_cnt_q;
    asm_d           = asm_q;
    command_d       = command_q;
    length_d        = length_q;
    data_d          = data_q;
    command_valid_d = 1'b0;
    data_valid_d    = 1'b0;
    packet_done_d   = 1'b0;

    if (bus.is_new_input_bit) begin
      case (state_q)
        StHunt: begin
          // fill_q counts bits already held; the current bit makes it full.
          if ((fill_q >= FillWidth'(HEADER_WIDTH - 1)) && (window_next == HEADER)) begin
            state_d   = StCommand;
            bit_cnt_d = '0;
            // Window and fill only change in hunt, so clearing them here means
            // every return to hunt starts from an empty window.
            window_d  = '0;
            fill_d    = '0;
          end else begin
            window_d = window_next[HEADER_WIDTH-2:0];
            if (fill_q != FillWidth'(HEADER_WIDTH)) begin
              fill_d = fill_q + FillWidth'(1);
            end
          end
        end

        StCommand: begin
          asm_d     = asm_next[AsmWidth-2:0];
          bit_cnt_d = bit_cnt_q + CntWidth'(1);
          if (bit_cnt_q == CntWidth'(COMMAND_WIDTH - 1)) begin
            command_d       = asm_next[COMMAND_WIDTH-1:0];
            command_valid_d = 1'b1;
            bit_cnt_d       = '0;
            state_d         = StLength;
          end
        end

        StLength: begin
          asm_d     = asm_next[AsmWidth-2:0];
          bit_cnt_d = bit_cnt_q + CntWidth'(1);
          if (bit_cnt_q == CntWidth'(LENGTH_WIDTH - 1)) begin
            length_d  = asm_next[LENGTH_WIDTH-1:0];
            bit_cnt_d = '0;
            if (asm_next[LENGTH_WIDTH-1:0] == '0) begin
              packet_done_d = 1'b1;
              state_d       = StHunt;
            end else begin
              word_cnt_d = '0;
              state_d    = StPayload;
            end
          end
        end

        StPayload: begin
          asm_d     = asm_next[AsmWidth-2:0];
          bit_cnt_d = bit_cnt_q + CntWidth'(1);
          if (bit_cnt_q == CntWidth'(DATA_WIDTH - 1)) begin
            data_d       = asm_next[DATA_WIDTH-1:0];
            data_valid_d = 1'b1;
            bit_cnt_d    = '0;
            word_cnt_d   = word_cnt_q + LENGTH_WIDTH'(1);
            // length_q is nonzero here, so length_q - 1 never wraps.
            if (word_cnt_q == (length_q - LENGTH_WIDTH'(1))) begin
              packet_done_d = 1'b1;
              state_d       = StHunt;
            end
          end
        end

        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StHunt;
      window_q        <= '0;
      fill_q          <= '0;
      bit_cnt_q       <= '0;
      word_cnt_q      <= '0;
      asm_q           <= '0;
      command_q       <= '0;
      command_valid_q <= 1'b0;
      length_q        <= '0;
      data_q          <= '0;
      data_valid_q    <= 1'b0;
      packet_done_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      window_q        <= window_d;
      fill_q          <= fill_d;
      bit_cnt_q       <= bit_cnt_d;
      word_cnt_q      <= word_cnt_d;
      asm_q           <= asm_d;
      command_q       <= command_d;
      command_valid_q <= command_valid_d;
      length_q        <= length_d;
      data_q          <= data_d;
      data_valid_q    <= data_valid_d;
      packet_done_q   <= packet_done_d;
    end
  end

  assign bus.command       = command_q;
  assign bus.command_valid = command_valid_q;
  assign bus.length        = length_q;
  assign bus.data_out      = data_q;
  assign bus.data_valid    = data_valid_q;
  assign bus.packet_done   = packet_done_q;
  assign bus.busy          = (state_q != StHunt);

endmodule

// File: tb/tb_stream_packet_parser.sv
// Bench for stream_packet_parser: directed and random bit streams, checked
// against a stream-level reference model (header search, then fixed fields).
module tb_stream_packet_parser;
  localparam int HW = 16;
  localparam int CW = 16;
  localparam int LW = 16;
  localparam int DW = 8;
  localparam logic [15:0] HDR = 16'hBACD;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stream_packet_parser_if #(.COMMAND_WIDTH(CW), .LENGTH_WIDTH(LW), .DATA_WIDTH(DW)) bus ();
  stream_packet_parser #(
    .HEADER_WIDTH(HW), .HEADER(HDR), .COMMAND_WIDTH(CW), .LENGTH_WIDTH(LW), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // Parameter variant: 8-bit header 7E, 4-bit length, 16-bit words.
  stream_packet_parser_if #(.COMMAND_WIDTH(16), .LENGTH_WIDTH(4), .DATA_WIDTH(16)) vbus ();
  stream_packet_parser #(
    .HEADER_WIDTH(8), .HEADER(8'h7E), .COMMAND_WIDTH(16), .LENGTH_WIDTH(4), .DATA_WIDTH(16)
  ) dut_v (
    .clk(clk), .rst(rst), .bus(vbus)
  );

  typedef struct {
    int          kind;  // 0 command, 1 data word, 2 packet done
    logic [31:0] val;
    int          idx;   // stream index of the bit completing the event
  } ev_t;

  int  n_cmp = 0;
  int  n_bad = 0;
  bit  stream[$];
  ev_t exp_q[$];
  ev_t obs_q[$];
  int  obs_base;
  bit  exp_busy;
  int  n_bits;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Qualified bits sampled since reset.
  always @(posedge clk) begin
    if (rst) n_bits <= 0;
    else if (bus.is_new_input_bit) n_bits <= n_bits + 1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.command_valid) obs_q.push_back('{0, 32'(bus.command), n_bits - 1});
      if (bus.data_valid)    obs_q.push_back('{1, 32'(bus.data_out), n_bits - 1});
      if (bus.packet_done)   obs_q.push_back('{2, 32'(bus.length), n_bits - 1});
    end
  end

  int          v_ndata = 0, v_ndone = 0, v_ncoinc = 0, v_ncmd = 0;
  logic [15:0] v_data = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (vbus.data_valid) begin
        v_ndata <= v_ndata + 1;
        v_data  <= vbus.data_out;
        if (vbus.packet_done) v_ncoinc <= v_ncoinc + 1;
      end
      if (vbus.packet_done)   v_ndone <= v_ndone + 1;
      if (vbus.command_valid) v_ncmd  <= v_ncmd + 1;
    end
  end

  task automatic push_field(input logic [31:0] v, input int w);
    for (int k = w - 1; k >= 0; k--) stream.push_back(v[k]);
  endtask

  function automatic logic [31:0] field(input int s, input int w);
    logic [31:0] v = '0;
    for (int k = 0; k < w; k++) v = {v[30:0], stream[s + k]};
    return v;
  endfunction

  // Reference: scan the stream for the first full header starting at pos,
  // read command and length, then length words; repeat from the next bit.
  task automatic run_model();
    int pos, hit, len;
    bit ok, stop;
    logic [31:0] v;
    exp_q.delete();
    exp_busy = 0;
    pos  = 0;
    stop = 0;
    while (!stop) begin
      hit = -1;
      for (int j = pos + HW - 1; j < stream.size() && hit < 0; j++) begin
        ok = 1;
        for (int k = 0; k < HW; k++) if (stream[j - HW + 1 + k] != HDR[HW - 1 - k]) ok = 0;
        if (ok) hit = j;
      end
      if (hit < 0) break;
      exp_busy = 1;
      pos = hit + 1;
      if (pos + CW > stream.size()) break;
      v = field(pos, CW);
      exp_q.push_back('{0, v, pos + CW - 1});
      pos += CW;
      if (pos + LW > stream.size()) break;
      len = int'(field(pos, LW));
      pos += LW;
      for (int w = 0; w < len; w++) begin
        if (pos + DW > stream.size()) begin
          stop = 1;
          break;
        end
        v = field(pos, DW);
        exp_q.push_back('{1, v, pos + DW - 1});
        pos += DW;
      end
      if (stop) break;
      exp_q.push_back('{2, 32'(len), pos - 1});
      exp_busy = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    obs_base = obs_q.size();
  endtask

  task automatic drive_stream(input int max_gap);
    for (int i = 0; i < stream.size(); i++) begin
      repeat ($urandom_range(max_gap, 0)) tick();
      bus.input_bit        = stream[i];
      bus.is_new_input_bit = 1'b1;
      tick();
      bus.is_new_input_bit = 1'b0;
      bus.input_bit        = 1'($urandom);
    end
  endtask

  task automatic compare(input string name);
    int nobs, n;
    repeat (4) tick();
    nobs = obs_q.size() - obs_base;
    check_eq({name, ".events"}, 64'(nobs), 64'(exp_q.size()));
    n = (nobs < exp_q.size()) ? nobs : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s.ev%0d.kind", name, i), 64'(obs_q[obs_base + i].kind),
               64'(exp_q[i].kind));
      check_eq($sformatf("%s.ev%0d.val", name, i), 64'(obs_q[obs_base + i].val),
               64'(exp_q[i].val));
      check_eq($sformatf("%s.ev%0d.idx", name, i), 64'(obs_q[obs_base + i].idx),
               64'(exp_q[i].idx));
    end
    check_eq({name, ".busy"}, 64'(bus.busy), 64'(exp_busy));
  endtask

  task automatic check_zero(input string name);
    check_eq({name, ".command"}, 64'(bus.command), 64'(0));
    check_eq({name, ".command_valid"}, 64'(bus.command_valid), 64'(0));
    check_eq({name, ".length"}, 64'(bus.length), 64'(0));
    check_eq({name, ".data_out"}, 64'(bus.data_out), 64'(0));
    check_eq({name, ".data_valid"}, 64'(bus.data_valid), 64'(0));
    check_eq({name, ".packet_done"}, 64'(bus.packet_done), 64'(0));
    check_eq({name, ".busy"}, 64'(bus.busy), 64'(0));
  endtask

  task automatic basic_stream(input logic [7:0] w0, input logic [7:0] w1);
    stream.delete();
    push_field(32'(HDR), HW);
    push_field(32'h1234, CW);
    push_field(32'h0002, LW);
    push_field(32'(w0), DW);
    push_field(32'(w1), DW);
  endtask

  initial begin
    logic [31:0] cmd;
    int          len;
    rst                   = 1'b1;
    bus.input_bit         = 1'b0;
    bus.is_new_input_bit  = 1'b0;
    vbus.input_bit        = 1'b0;
    vbus.is_new_input_bit = 1'b0;
    repeat (3) tick();
    check_zero("reset");
    rst = 1'b0;

    // Basic packet, continuous bits.
    do_reset();
    basic_stream(8'hA5, 8'h3C);
    run_model();
    drive_stream(0);
    compare("basic");
    check_eq("basic.command_held", 64'(bus.command), 64'h1234);
    check_eq("basic.data_held", 64'(bus.data_out), 64'h3C);
    check_eq("basic.length_held", 64'(bus.length), 64'h2);

    // Unaligned header after junk bits, zero-length packet.
    do_reset();
    stream.delete();
    push_field(32'b101, 3);
    push_field(32'(HDR), HW);
    push_field(32'h00FF, CW);
    push_field(32'h0000, LW);
    run_model();
    drive_stream(0);
    compare("sliding");
    check_eq("sliding.command_held", 64'(bus.command), 64'h00FF);

    // Same as basic, with idle cycles between bits.
    do_reset();
    basic_stream(8'hA5, 8'h3C);
    run_model();
    drive_stream(5);
    compare("gapped");

    // Header bytes inside the payload are data.
    do_reset();
    basic_stream(8'hBA, 8'hCD);
    run_model();
    drive_stream(1);
    compare("false_hdr");

    // Reset after four payload bits, with a qualified bit in the reset cycle.
    do_reset();
    stream.delete();
    push_field(32'(HDR), HW);
    push_field(32'h5A5A, CW);
    push_field(32'h0003, LW);
    push_field(32'hF, 4);
    run_model();
    drive_stream(0);
    compare("midreset.pre");
    rst                  = 1'b1;
    bus.is_new_input_bit = 1'b1;
    bus.input_bit        = 1'b1;
    tick();
    check_zero("midreset");
    rst                  = 1'b0;
    bus.is_new_input_bit = 1'b0;
    tick();
    check_eq("midreset.no_done", 64'(bus.packet_done), 64'(0));
    stream.delete();
    push_field(32'(HDR), HW);
    push_field(32'hC001, CW);
    push_field(32'h0001, LW);
    push_field(32'h96, DW);
    obs_base = obs_q.size();
    // n_bits was cleared by the reset edge; no bits were sent since.
    run_model();
    drive_stream(0);
    compare("midreset.post");

    // Random streams: junk, 1-3 packets, junk between, random gaps.
    for (int it = 0; it < 25; it++) begin
      do_reset();
      stream.delete();
      push_field($urandom, $urandom_range(8, 0));
      for (int p = 0; p < int'($urandom_range(3, 1)); p++) begin
        push_field(32'(HDR), HW);
        cmd = $urandom;
        if ($urandom_range(3, 0) == 0) cmd = 32'(HDR);
        push_field(cmd, CW);
        len = $urandom_range(3, 0);
        push_field(32'(len), LW);
        for (int w = 0; w < len; w++) begin
          cmd = $urandom;
          if ($urandom_range(2, 0) == 0) cmd = (w % 2 == 0) ? 32'hBA : 32'hCD;
          push_field(cmd, DW);
        end
        push_field($urandom, $urandom_range(5, 0));
      end
      run_model();
      drive_stream($urandom_range(2, 0));
      compare($sformatf("rand%0d", it));
    end

    // Parameter variant.
    do_reset();
    stream.delete();
    push_field(32'h7E, 8);
    push_field(32'hC0DE, 16);
    push_field(32'h1, 4);
    push_field(32'hBEEF, 16);
    for (int i = 0; i < stream.size(); i++) begin
      vbus.input_bit        = stream[i];
      vbus.is_new_input_bit = 1'b1;
      tick();
    end
    vbus.is_new_input_bit = 1'b0;
    repeat (4) tick();
    check_eq("variant.ncmd", 64'(v_ncmd), 64'(1));
    check_eq("variant.command", 64'(vbus.command), 64'hC0DE);
    check_eq("variant.ndata", 64'(v_ndata), 64'(1));
    check_eq("variant.data", 64'(v_data), 64'hBEEF);
    check_eq("variant.ndone", 64'(v_ndone), 64'(1));
    check_eq("variant.coincident", 64'(v_ncoinc), 64'(1));
    check_eq("variant.length", 64'(vbus.length), 64'(1));
    check_eq("variant.busy", 64'(vbus.busy), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/stream_packet_parser.md
# stream_packet_parser

Bit-serial packet framer that replaces the fixed 16-bit header/command parser at the front of the peripheral receive path. It hunts for a parametrised header with a sliding bit window, then captures a command field and a payload length field. It deserialises exactly that many payload words and returns to hunting, so the receive path accepts back-to-back packets without a reset. Downstream blocks (image buffer, command dispatcher) consume word-wide `data_out` strobes and a one-cycle `command_valid` pulse.

## Interface
Parameters:
- `HEADER_WIDTH`, 16: header field width in bits.
- `HEADER`, 16'hBACD: header value, `HEADER_WIDTH` bits, transmitted MSB first.
- `COMMAND_WIDTH`, 16: command field width in bits.
- `LENGTH_WIDTH`, 16: payload length field width; the length counts payload words.
- `DATA_WIDTH`, 8: payload word width in bits.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `input_bit` in 1: serial data bit.
- `is_new_input_bit` in 1: qualifies `input_bit` for one cycle; bits on cycles where it is low are ignored.
- `command` out `COMMAND_WIDTH`: last captured command; held until the next capture.
- `command_valid` out 1: one-cycle pulse when `command` updates.
- `length` out `LENGTH_WIDTH`: payload length of the current/last packet; held.
- `data_out` out `DATA_WIDTH`: last assembled payload word; held.
- `data_valid` out 1: one-cycle pulse per payload word.
- `packet_done` out 1: one-cycle pulse at packet end.
- `busy` out 1: high in every state except HUNT.

## Operation
- All fields are transmitted MSB first.
- **States:** HUNT, COMMAND, LENGTH, PAYLOAD. One bit counter sized for the widest field; a separate `LENGTH_WIDTH`-bit word counter.
- **HUNT:**
  - Each qualified bit shifts into a `HEADER_WIDTH` window; a fill counter saturates at `HEADER_WIDTH`.
  - Match when the fill counter is full and {window[HEADER_WIDTH-2:0], input_bit} == `HEADER`. The match is sliding and not aligned to any bit boundary.
  - On match, go to COMMAND.
- **COMMAND:**
  - Collect `COMMAND_WIDTH` bits.
  - On the last bit, load `command` and pulse `command_valid`, then go to LENGTH.
- **LENGTH:**
  - Collect `LENGTH_WIDTH` bits.
  - On the last bit, load `length`.
  - If the value is 0, pulse `packet_done` and go to HUNT.
  - Otherwise clear the word counter and go to PAYLOAD.
- **PAYLOAD:**
  - Shift bits into a `DATA_WIDTH` assembler.
  - On each word's last bit, load `data_out`, pulse `data_valid` and increment the word counter.
  - When that word is word number `length`, pulse `packet_done` in the same cycle as `data_valid` and go to HUNT.
- **Entering HUNT** from any state clears the window and the fill counter, so a new header needs a full `HEADER_WIDTH` fresh bits. Payload bits never contribute to header detection.
- **Header-like patterns** inside COMMAND, LENGTH or PAYLOAD are data, not resynchronisation.
- **Maximum length** is 2^LENGTH_WIDTH-1 words; the word counter never wraps within a packet.

## Timing
- **Reset values:** all outputs 0. State HUNT; window, fill counter, bit counter and word counter all 0.
- **Reset mid-packet** abandons the packet with no `packet_done`; the next cycle is in HUNT.
- **Registered outputs:** a field-completing bit sampled at edge N makes the updated output and its pulse visible from edge N to edge N+1. Pulses last exactly one cycle even if `is_new_input_bit` stays high.
- **Back-to-back input:** bits on consecutive cycles are supported. Header-match to COMMAND has zero dead bits; the next qualified bit is command bit MSB.
- **Back-to-back packets:** after `packet_done`, the next qualified bit is the first bit of a new header window.
- **Reset priority:** `rst` has priority over `is_new_input_bit` in the same cycle.
- **Latency:** one cycle from the last bit of a field to its output.

## Test plan
- **Basic packet:** reset, then stream BACD, command 0x1234, length 0x0002, payload 0xA5, 0x3C with continuous valid bits -> `command_valid` 1 cycle with `command`=0x1234; `data_valid` twice with 0xA5 then 0x3C; `packet_done` coincident with the 0x3C strobe; `busy` returns to 0.
- **Sliding hunt:** 3 junk bits 101, then BACD, command 0x00FF, length 0 -> header found at the unaligned offset; `command`=0x00FF; `packet_done` pulse with no `data_valid`.
- **Gapped bits:** same as the basic packet but with random 0–5 idle cycles (`is_new_input_bit`=0) between bits -> identical outputs; each pulse is exactly 1 cycle.
- **False header in payload:** length 2, payload 0xBA, 0xCD -> emitted as data; only one `command_valid` for the packet.
- **Reset mid-payload:** assert `rst` after 4 payload bits -> all outputs 0 next cycle, no `packet_done`. A following full packet parses correctly.
- **Parameter variant:** `HEADER_WIDTH`=8, `HEADER`=8'h7E, `DATA_WIDTH`=16, `LENGTH_WIDTH`=4, stream 7E, command, length 1, word 0xBEEF -> one `data_valid` with 0xBEEF plus `packet_done`.
